spi_accel_responder: RTL and testbench

- SPI mode-3 target that emulates the on-board accelerometer's register interface: 6-bit address, R/W and multi-byte (MB) command bits, and little-endian axis data at 0x32-0x37.
- It sits at the far end of the GSENSOR SPI lines, looped through GPIO, so the signal-path SPI master and the Nios software can be exercised in hardware against deterministic, injected samples.
- All logic runs in the sys_clk domain. SPI pins are oversampled.

---
 rtl/spi_accel_pkg.sv | 34 +++
 rtl/spi_pin_sync.sv | 69 ++++++
 rtl/spi_accel_responder.sv | 198 +++++++++++++++++++
 tb/tb_spi_accel_responder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_accel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_accel_pkg
// Description : Register map, FSM state type and address helpers shared by
//               the accelerometer SPI responder.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_accel_pkg;

    localparam logic [5:0] ADDR_DEVID       = 6'h00;
    localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
    localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
    localparam logic [5:0] ADDR_INT_ENABLE  = 6'h2E;
    localparam logic [5:0] ADDR_INT_SOURCE  = 6'h30;
    localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
    localparam logic [5:0] ADDR_DATAX0      = 6'h32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } spi_state_t;

    function automatic logic is_writable(input logic [5:0] addr);
        return (addr == ADDR_BW_RATE) || (addr == ADDR_POWER_CTL) ||
               (addr == ADDR_INT_ENABLE) || (addr == ADDR_DATA_FORMAT);
    endfunction

    function automatic logic is_data_addr(input logic [5:0] addr);
        return (addr >= ADDR_DATAX0) && (addr <= ADDR_DATAX0 + 6'd5);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_pin_sync.sv
`default_nettype none
// ============================================================================
// Module      : spi_pin_sync
// Description : Synchronises the SPI pins into clk and produces registered
//               sclk rise/fall and chip-select edge strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sclk,
    input  logic i_cs_n,
    input  logic i_mosi,
    output logic o_sclk_rise,
    output logic o_sclk_fall,
    output logic o_cs_fall,
    output logic o_cs_rise,
    output logic o_cs_n,
    output logic o_mosi
);

    logic [SYNC_STAGES-1:0] r_sclk_pipe;
    logic [SYNC_STAGES-1:0] r_cs_pipe;
    logic [SYNC_STAGES-1:0] r_mosi_pipe;
    logic                   r_sclk_q;
    logic                   r_cs_q;
    logic                   r_mosi_q;
    logic                   w_sclk;
    logic                   w_cs;
    logic                   w_mosi;

    assign w_sclk = r_sclk_pipe[SYNC_STAGES-1];
    assign w_cs   = r_cs_pipe[SYNC_STAGES-1];
    assign w_mosi = r_mosi_pipe[SYNC_STAGES-1];

    // The _q level registers keep mosi and cs aligned with the edge strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_pipe <= '1;
            r_cs_pipe   <= '1;
            r_mosi_pipe <= '0;
            r_sclk_q    <= 1'b1;
            r_cs_q      <= 1'b1;
            r_mosi_q    <= 1'b0;
            o_sclk_rise <= 1'b0;
            o_sclk_fall <= 1'b0;
            o_cs_fall   <= 1'b0;
            o_cs_rise   <= 1'b0;
        end else begin
            r_sclk_pipe <= {r_sclk_pipe[SYNC_STAGES-2:0], i_sclk};
            r_cs_pipe   <= {r_cs_pipe[SYNC_STAGES-2:0], i_cs_n};
            r_mosi_pipe <= {r_mosi_pipe[SYNC_STAGES-2:0], i_mosi};
            r_sclk_q    <= w_sclk;
            r_cs_q      <= w_cs;
            r_mosi_q    <= w_mosi;
            o_sclk_rise <= w_sclk & ~r_sclk_q;
            o_sclk_fall <= ~w_sclk & r_sclk_q;
            o_cs_fall   <= ~w_cs & r_cs_q;
            o_cs_rise   <= w_cs & ~r_cs_q;
        end
    end

    assign o_cs_n = r_cs_q;
    assign o_mosi = r_mosi_q;

endmodule
`default_nettype wire

// File: rtl/spi_accel_responder.sv
`default_nettype none
// ============================================================================
// Module      : spi_accel_responder
// Description : SPI mode-3 target emulating the accelerometer register file,
//               presenting injected axis samples with tear-free burst reads.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_accel_responder
    import spi_accel_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] DEVID       = 8'hE5
) (
    input  logic        sys_clk,
    input  logic        reset_n,
    input  logic        spi_sclk,
    input  logic        spi_cs,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    input  logic [15:0] x_sample,
    input  logic [15:0] y_sample,
    input  logic [15:0] z_sample,
    input  logic        sample_valid,
    output logic        data_ready_int,
    output logic        reg_wr_en,
    output logic [5:0]  reg_wr_addr,
    output logic [7:0]  reg_wr_data
);

    logic        w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise, w_cs_n, w_mosi;
    spi_state_t  r_state;
    logic [2:0]  r_bit_cnt;
    logic [6:0]  r_rx_shift;
    logic [7:0]  r_tx_shift;
    logic        r_rw, r_mb;
    logic [5:0]  r_addr;
    logic [7:0]  r_bw_rate, r_power_ctl, r_int_enable, r_data_format;
    logic [47:0] r_data, r_shadow;
    logic        r_shadow_pending, r_data_ready, r_data_read;
    logic [7:0]  w_byte;
    logic [5:0]  w_next_addr, w_rd_addr;
    logic [7:0]  w_rd_data;
    logic [47:0] w_samples;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pin_sync (
        .clk         (sys_clk),
        .rst_n       (reset_n),
        .i_sclk      (spi_sclk),
        .i_cs_n      (spi_cs),
        .i_mosi      (spi_mosi),
        .o_sclk_rise (w_sclk_rise),
        .o_sclk_fall (w_sclk_fall),
        .o_cs_fall   (w_cs_fall),
        .o_cs_rise   (w_cs_rise),
        .o_cs_n      (w_cs_n),
        .o_mosi      (w_mosi)
    );

    assign w_byte      = {r_rx_shift, w_mosi};
    assign w_next_addr = r_mb ? r_addr + 6'd1 : r_addr;
    assign w_samples   = {z_sample, y_sample, x_sample};
    // Only one register lookup per cycle: the command address or the prefetch.
    assign w_rd_addr   = (r_state == CMD) ? w_byte[5:0] : w_next_addr;

    always_comb begin
        w_rd_data = 8'h00;
        case (w_rd_addr)
            ADDR_DEVID:         w_rd_data = DEVID;
            ADDR_BW_RATE:       w_rd_data = r_bw_rate;
            ADDR_POWER_CTL:     w_rd_data = r_power_ctl;
            ADDR_INT_ENABLE:    w_rd_data = r_int_enable;
            ADDR_INT_SOURCE:    w_rd_data = {r_data_ready, 7'b0};
            ADDR_DATA_FORMAT:   w_rd_data = r_data_format;
            ADDR_DATAX0:        w_rd_data = r_data[7:0];
            ADDR_DATAX0 + 6'd1: w_rd_data = r_data[15:8];
            ADDR_DATAX0 + 6'd2: w_rd_data = r_data[23:16];
            ADDR_DATAX0 + 6'd3: w_rd_data = r_data[31:24];
            ADDR_DATAX0 + 6'd4: w_rd_data = r_data[39:32];
            ADDR_DATAX0 + 6'd5: w_rd_data = r_data[47:40];
            default:            w_rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= IDLE;
            r_bit_cnt        <= 3'd0;
            r_rx_shift       <= 7'd0;
            r_tx_shift       <= 8'd0;
            r_rw             <= 1'b0;
            r_mb             <= 1'b0;
            r_addr           <= 6'd0;
            r_bw_rate        <= 8'd0;
            r_power_ctl      <= 8'd0;
            r_int_enable     <= 8'd0;
            r_data_format    <= 8'd0;
            r_data           <= 48'd0;
            r_shadow         <= 48'd0;
            r_shadow_pending <= 1'b0;
            r_data_ready     <= 1'b0;
            r_data_read      <= 1'b0;
            spi_miso         <= 1'b1;
            reg_wr_en        <= 1'b0;
            reg_wr_addr      <= 6'd0;
            reg_wr_data      <= 8'd0;
        end else begin
            reg_wr_en <= 1'b0;

            if (sample_valid && !w_cs_n) begin
                r_shadow         <= w_samples;
                r_shadow_pending <= 1'b1;
            end
            // End of transaction: read-clear first, then a pending apply sets.
            if (w_cs_rise) begin
                r_shadow_pending <= 1'b0;
                r_data_read      <= 1'b0;
                if (r_data_read)
                    r_data_ready <= 1'b0;
                if (r_shadow_pending) begin
                    r_data       <= r_shadow;
                    r_data_ready <= 1'b1;
                end
            end
            if (sample_valid && w_cs_n) begin
                r_data       <= w_samples;
                r_data_ready <= 1'b1;
            end

            if (w_cs_n) begin
                r_state   <= IDLE;
                r_bit_cnt <= 3'd0;
                spi_miso  <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_cs_fall) begin
                            r_state   <= CMD;
                            r_bit_cnt <= 3'd0;
                        end
                    end
                    CMD: begin
                        if (w_sclk_rise) begin
                            r_rx_shift <= w_byte[6:0];
                            r_bit_cnt  <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_rw    <= w_byte[7];
                                r_mb    <= w_byte[6];
                                r_addr  <= w_byte[5:0];
                                r_state <= DATA;
                                if (w_byte[7])
                                    r_tx_shift <= w_rd_data;
                            end
                        end
                    end
                    DATA: begin
                        if (r_rw) begin
                            if (w_sclk_fall) begin
                                spi_miso   <= r_tx_shift[7];
                                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                                r_bit_cnt  <= r_bit_cnt + 3'd1;
                                if (r_bit_cnt == 3'd0 && is_data_addr(r_addr))
                                    r_data_read <= 1'b1;
                                if (r_bit_cnt == 3'd7) begin
                                    r_addr     <= w_next_addr;
                                    r_tx_shift <= w_rd_data;
                                end
                            end
                        end else if (w_sclk_rise) begin
                            r_rx_shift <= w_byte[6:0];
                            r_bit_cnt  <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                if (is_writable(r_addr)) begin
                                    case (r_addr)
                                        ADDR_BW_RATE:    r_bw_rate     <= w_byte;
                                        ADDR_POWER_CTL:  r_power_ctl   <= w_byte;
                                        ADDR_INT_ENABLE: r_int_enable  <= w_byte;
                                        default:         r_data_format <= w_byte;
                                    endcase
                                    reg_wr_en   <= 1'b1;
                                    reg_wr_addr <= r_addr;
                                    reg_wr_data <= w_byte;
                                end
                                r_addr <= w_next_addr;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign spi_miso_oe    = ~w_cs_n;
    assign data_ready_int = r_data_ready & r_int_enable[7];

endmodule
`default_nettype wire

// File: tb/tb_spi_accel_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_accel_responder
// Description : Self-checking bench: SPI master tasks driving directed and
//               randomized transactions against a register-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_spi_accel_responder;

    localparam int HALF = 5;

    logic        sys_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        spi_sclk = 1'b1;
    logic        spi_cs = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] x_sample = '0, y_sample = '0, z_sample = '0;
    logic        spi_miso, spi_miso_oe, data_ready_int, reg_wr_en;
    logic [5:0]  reg_wr_addr;
    logic [7:0]  reg_wr_data;

    always #5 sys_clk = ~sys_clk;

    spi_accel_responder #(.SYNC_STAGES(2), .DEVID(8'hE5)) dut (
        .sys_clk        (sys_clk),
        .reset_n        (reset_n),
        .spi_sclk       (spi_sclk),
        .spi_cs         (spi_cs),
        .spi_mosi       (spi_mosi),
        .spi_miso       (spi_miso),
        .spi_miso_oe    (spi_miso_oe),
        .x_sample       (x_sample),
        .y_sample       (y_sample),
        .z_sample       (z_sample),
        .sample_valid   (sample_valid),
        .data_ready_int (data_ready_int),
        .reg_wr_en      (reg_wr_en),
        .reg_wr_addr    (reg_wr_addr),
        .reg_wr_data    (reg_wr_data)
    );

    int          checks = 0;
    int          failures = 0;
    logic [13:0] wr_q[$];
    logic [7:0]  tx_bytes[16];
    logic [7:0]  rx_bytes[16];
    int          inj_after = -1;
    logic [15:0] inj_x, inj_y, inj_z;

    // Reference model state
    logic [7:0]  m_reg[64];
    logic [15:0] m_x = '0, m_y = '0, m_z = '0;
    bit          m_ready = 1'b0;

    always @(negedge sys_clk)
        if (reg_wr_en) wr_q.push_back({reg_wr_addr, reg_wr_data});

    initial begin
        #900us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_writable(input logic [5:0] a);
        return a == 6'h2C || a == 6'h2D || a == 6'h2E || a == 6'h31;
    endfunction

    function automatic bit m_is_data(input logic [5:0] a);
        return a >= 6'h32 && a <= 6'h37;
    endfunction

    function automatic logic [7:0] m_read(input logic [5:0] a);
        logic [47:0] d;
        d = {m_z, m_y, m_x};
        if (a == 6'h00)      return 8'hE5;
        if (m_writable(a))   return m_reg[a];
        if (a == 6'h30)      return {m_ready, 7'b0};
        if (m_is_data(a))    return d[8*(a-6'h32) +: 8];
        return 8'h00;
    endfunction

    task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        x_sample = x; y_sample = y; z_sample = z;
        sample_valid = 1'b1;
        @(negedge sys_clk);
        sample_valid = 1'b0;
    endtask

    // Mode 3: data changes on sclk fall, both sides sample on sclk rise.
    task automatic spi_txn(input int nbytes, input int tail_bits);
        spi_cs = 1'b0;
        repeat (HALF) @(negedge sys_clk);
        for (int b = 0; b < nbytes; b++) begin
            for (int i = 7; i >= 0; i--) begin
                spi_sclk = 1'b0;
                spi_mosi = tx_bytes[b][i];
                repeat (HALF) @(negedge sys_clk);
                rx_bytes[b][i] = spi_miso;
                spi_sclk = 1'b1;
                repeat (HALF) @(negedge sys_clk);
            end
            if (b == inj_after) pulse_sample(inj_x, inj_y, inj_z);
        end
        for (int i = 7; i > 7 - tail_bits; i--) begin
            spi_sclk = 1'b0;
            spi_mosi = tx_bytes[nbytes][i];
            repeat (HALF) @(negedge sys_clk);
            spi_sclk = 1'b1;
            repeat (HALF) @(negedge sys_clk);
        end
        spi_cs = 1'b1;
        repeat (12) @(negedge sys_clk);
        inj_after = -1;
    endtask

    task automatic check_int();
        check_eq("data_ready_int", data_ready_int, m_ready & m_reg[6'h2E][7]);
    endtask

    task automatic do_read(input logic [5:0] addr, input bit mb, input int n, input int inj,
                           input logic [15:0] ix, input logic [15:0] iy, input logic [15:0] iz);
        logic [7:0] exp[8];
        logic [5:0] a;
        bit touched = 1'b0;
        tx_bytes[0] = {1'b1, mb, addr};
        for (int i = 0; i < n; i++) begin
            a = mb ? addr + 6'(i) : addr;
            exp[i] = m_read(a);
            if (m_is_data(a)) touched = 1'b1;
            tx_bytes[i+1] = 8'($urandom);
        end
        inj_after = inj; inj_x = ix; inj_y = iy; inj_z = iz;
        spi_txn(n + 1, 0);
        for (int i = 0; i < n; i++)
            check_eq($sformatf("rd_a%0h_b%0d", addr, i), rx_bytes[i+1], exp[i]);
        if (touched) m_ready = 1'b0;
        if (inj >= 0) begin
            m_x = ix; m_y = iy; m_z = iz; m_ready = 1'b1;
        end
        check_eq("rd_no_wr_pulse", wr_q.size(), 0);
        wr_q.delete();
        check_int();
    endtask

    task automatic do_write(input logic [5:0] addr, input bit mb, input int n, input logic [7:0] d0);
        logic [13:0] exp[8];
        logic [13:0] got;
        logic [5:0]  a;
        int          nexp = 0;
        tx_bytes[0] = {1'b0, mb, addr};
        for (int i = 0; i < n; i++) begin
            tx_bytes[i+1] = (i == 0) ? d0 : 8'($urandom);
            a = mb ? addr + 6'(i) : addr;
            if (m_writable(a)) begin
                m_reg[a] = tx_bytes[i+1];
                exp[nexp] = {a, tx_bytes[i+1]};
                nexp++;
            end
        end
        spi_txn(n + 1, 0);
        check_eq($sformatf("wr_a%0h_pulses", addr), wr_q.size(), nexp);
        for (int i = 0; i < nexp; i++) begin
            if (wr_q.size() > 0) begin
                got = wr_q.pop_front();
                check_eq($sformatf("wr_a%0h_pulse%0d", addr, i), got, exp[i]);
            end
        end
        wr_q.delete();
        check_int();
    endtask

    task automatic do_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        pulse_sample(x, y, z);
        m_x = x; m_y = y; m_z = z; m_ready = 1'b1;
        repeat (2) @(negedge sys_clk);
        check_int();
    endtask

    initial begin
        logic [5:0] ra;
        for (int i = 0; i < 64; i++) m_reg[i] = 8'h00;

        repeat (3) @(negedge sys_clk);
        check_eq("rst_miso", spi_miso, 1'b1);
        check_eq("rst_miso_oe", spi_miso_oe, 1'b0);
        check_eq("rst_data_ready_int", data_ready_int, 1'b0);
        check_eq("rst_wr_en", reg_wr_en, 1'b0);
        check_eq("rst_wr_addr_data", {reg_wr_addr, reg_wr_data}, 14'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge sys_clk);

        // DEVID read
        do_read(6'h00, 1'b0, 1, -1, '0, '0, '0);
        // Enable the data-ready interrupt, then burst-read a capture
        do_write(6'h2E, 1'b0, 1, 8'h80);
        do_sample(16'h1234, 16'hFF01, 16'h0080);
        check_eq("int_after_capture", data_ready_int, 1'b1);
        do_read(6'h32, 1'b1, 6, -1, '0, '0, '0);
        check_eq("burst_x0", rx_bytes[1], 8'h34);
        check_eq("burst_z1", rx_bytes[6], 8'h00);
        check_eq("int_after_read", data_ready_int, 1'b0);

        // Write / readback, and ignored write to DEVID
        do_write(6'h31, 1'b0, 1, 8'h0B);
        do_read(6'h31, 1'b0, 1, -1, '0, '0, '0);
        do_write(6'h00, 1'b0, 1, 8'h55);
        do_read(6'h00, 1'b0, 1, -1, '0, '0, '0);

        // Tear protection
        do_sample(16'h1111, 16'h0, 16'h0);
        do_read(6'h32, 1'b1, 2, 1, 16'h2222, 16'h0, 16'h0);
        check_eq("tear_int_stays", data_ready_int, 1'b1);
        do_read(6'h32, 1'b1, 2, -1, '0, '0, '0);

        // Abort a write after 4 data bits
        tx_bytes[0] = 8'h2D;
        tx_bytes[1] = 8'hFF;
        spi_txn(1, 4);
        check_eq("abort_no_pulse", wr_q.size(), 0);
        wr_q.delete();
        do_read(6'h2D, 1'b0, 1, -1, '0, '0, '0);

        // Address wrap and non-MB repeat
        do_read(6'h3F, 1'b1, 2, -1, '0, '0, '0);
        do_read(6'h32, 1'b0, 3, -1, '0, '0, '0);

        // Randomized mix
        for (int it = 0; it < 40; it++) begin
            ra = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 63))
                                             : 6'h2C + 6'($urandom_range(0, 11));
            case ($urandom_range(0, 3))
                0: do_write(ra, 1'($urandom_range(0, 1)), $urandom_range(1, 3), 8'($urandom));
                1: do_read(ra, 1'($urandom_range(0, 1)), $urandom_range(1, 4), -1, '0, '0, '0);
                2: do_read(ra, 1'($urandom_range(0, 1)), $urandom_range(1, 4),
                           $urandom_range(0, 2), 16'($urandom), 16'($urandom), 16'($urandom));
                default: do_sample(16'($urandom), 16'($urandom), 16'($urandom));
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
